// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
//   state_e - arbiter FSM encoding (2 bits)
//   M0/M1   - master identifiers as carried on grant_id / last_grant
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic M0 = 1'b0;   // CPU
    localparam logic M1 = 1'b1;   // loader / debug

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of the two master ports and the memory port.
//   m0_*/m1_*  - req/we/addr/wdata from masters, ack/rdata back to them
//   mem_*      - registered address/write data, read/write enables, read data
//   grant_id   - master owning the current/last access
//   busy       - arbiter not idle
// Modports: slave (arbiter side), master (masters + memory side).
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req,   m1_req;
    logic          m0_we,    m1_we;
    logic [AW-1:0] m0_addr,  m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack,   m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_rdata;
    logic          grant_id;
    logic          busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, mem_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata, mem_addr, mem_wdata,
               mem_write, mem_read, grant_id, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, mem_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata, mem_addr, mem_wdata,
               mem_write, mem_read, grant_id, busy
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0]   - request from master 1 / master 0
//   last_grant - master granted most recently
//   winner     - chosen master (meaningful when valid)
//   valid      - at least one request present
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = M0;
        if (&req)
            winner = ~last_grant;   // tie: whoever did not go last
        else if (req[1])
            winner = M1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of a single-port data memory.
// Each access takes IDLE -> ACCESS -> RESP (3 cycles); requests are only
// sampled in IDLE so a held request is never double-served.
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-low
//   bus        - dmem_arbiter_if.slave: master ports, memory port, status
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    state_e        state, state_nxt;
    logic          win, win_vld, latch;
    logic          grant_id, last_grant, op_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, m0_rdata, m1_rdata;
    logic          mem_write, mem_read, m0_ack, m1_ack;

    rr_arb2 u_arb (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_grant (last_grant),
        .winner     (win),
        .valid      (win_vld)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Enables and acks decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = ACCESS;
                    latch     = 1'b1;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                mem_write = op_we;
                mem_read  = ~op_we;
            end
            RESP: begin
                state_nxt = IDLE;
                m0_ack    = (grant_id == M0);
                m1_ack    = (grant_id == M1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant differs from grant_id only out of reset, where it is M1 so
    // that master 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            op_we      <= 1'b0;
            grant_id   <= M0;
            last_grant <= M1;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (latch) begin
                grant_id   <= win;
                last_grant <= win;
                op_we      <= (win == M1) ? bus.m1_we    : bus.m0_we;
                mem_addr   <= (win == M1) ? bus.m1_addr  : bus.m0_addr;
                mem_wdata  <= (win == M1) ? bus.m1_wdata : bus.m0_wdata;
            end
            if (state == ACCESS && !op_we) begin
                if (grant_id == M1) m1_rdata <= bus.mem_rdata;
                else                m0_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_write = mem_write;
    assign bus.mem_read  = mem_read;
    assign bus.m0_ack    = m0_ack;
    assign bus.m1_ack    = m1_ack;
    assign bus.m0_rdata  = m0_rdata;
    assign bus.m1_rdata  = m1_rdata;
    assign bus.grant_id  = grant_id;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errs   = 0;
    int   checks = 0;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural memory: 256 words indexed by the low address byte.
    logic [DW-1:0] dmem    [0:255];
    logic [DW-1:0] ref_mem [0:255];
    bit            mem_ready = 1'b0;

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 16'h1234;
        return {a, ~a};
    endfunction

    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) dmem[i] = init_val(8'(i));
            mem_ready = 1'b1;
        end else if (bus.mem_write) begin
            dmem[bus.mem_addr[7:0]] = bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];

    // Reference arbitration state: who was granted most recently.
    logic model_last;

    task automatic idle_masters();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b0; idle_masters();
        @(negedge clock); reset = 1'b1; model_last = M1;
    endtask

    task automatic test_reset();
        idle_masters();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if ({bus.busy, bus.m0_ack, bus.m1_ack} !== 3'b000)
            begin errs++; $display("FAIL reset_busy_ack: got %b want 000", {bus.busy, bus.m0_ack, bus.m1_ack}); end
        checks++; if ({bus.mem_write, bus.mem_read, bus.grant_id} !== 3'b000)
            begin errs++; $display("FAIL reset_en_gid: got %b want 000", {bus.mem_write, bus.mem_read, bus.grant_id}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 32'h0)
            begin errs++; $display("FAIL reset_mem_regs: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        checks++; if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0)
            begin errs++; $display("FAIL reset_rdata: got %h want 0", {bus.m0_rdata, bus.m1_rdata}); end
        reset = 1'b1; model_last = M1;
    endtask

    task automatic test_read();
        @(negedge clock);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0010;
        @(negedge clock);   // ACCESS
        checks++; if ({bus.mem_read, bus.mem_write, bus.busy} !== 3'b101)
            begin errs++; $display("FAIL rd_access_en: got %b want 101", {bus.mem_read, bus.mem_write, bus.busy}); end
        checks++; if (bus.mem_addr !== 16'h0010)
            begin errs++; $display("FAIL rd_mem_addr: got %h want 0010", bus.mem_addr); end
        @(negedge clock);   // RESP
        checks++; if ({bus.m0_ack, bus.m1_ack, bus.mem_read} !== 3'b100)
            begin errs++; $display("FAIL rd_ack: got %b want 100", {bus.m0_ack, bus.m1_ack, bus.mem_read}); end
        checks++; if (bus.m0_rdata !== 16'h1234)
            begin errs++; $display("FAIL rd_data: got %h want 1234", bus.m0_rdata); end
        bus.m0_req = 1'b0; model_last = M0;
        @(negedge clock);
        checks++; if ({bus.busy, bus.m0_ack} !== 2'b00)
            begin errs++; $display("FAIL rd_idle: got %b want 00", {bus.busy, bus.m0_ack}); end
    endtask

    task automatic test_write_readback();
        @(negedge clock);
        bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 16'h0020; bus.m1_wdata = 16'hBEEF;
        @(negedge clock);
        checks++; if ({bus.mem_write, bus.mem_read, bus.grant_id} !== 3'b101)
            begin errs++; $display("FAIL wr_access_en: got %b want 101", {bus.mem_write, bus.mem_read, bus.grant_id}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 32'h0020BEEF)
            begin errs++; $display("FAIL wr_addr_data: got %h want 0020beef", {bus.mem_addr, bus.mem_wdata}); end
        @(negedge clock);
        checks++; if ({bus.m0_ack, bus.m1_ack} !== 2'b01)
            begin errs++; $display("FAIL wr_ack: got %b want 01", {bus.m0_ack, bus.m1_ack}); end
        checks++; if (bus.m1_rdata !== 16'h0)
            begin errs++; $display("FAIL wr_rdata_kept: got %h want 0000", bus.m1_rdata); end
        ref_mem[8'h20] = 16'hBEEF; model_last = M1;
        bus.m1_we = 1'b0; bus.m1_req = 1'b0;
        @(negedge clock);
        bus.m1_req = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if ({bus.m1_ack, bus.m1_rdata} !== {1'b1, ref_mem[8'h20]})
            begin errs++; $display("FAIL wr_readback: got %b/%h want 1/%h", bus.m1_ack, bus.m1_rdata, ref_mem[8'h20]); end
        checks++; if (bus.m0_rdata !== 16'h1234)
            begin errs++; $display("FAIL wr_other_rdata: got %h want 1234", bus.m0_rdata); end
        bus.m1_req = 1'b0;
    endtask

    task automatic test_both_from_reset();
        do_reset();
        bus.m0_req = 1'b1; bus.m0_addr = 16'h0030;
        bus.m1_req = 1'b1; bus.m1_addr = 16'h0040;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            checks++;
            if ({bus.m0_ack, bus.m1_ack} !== {(c == 2 || c == 8), (c == 5)})
                begin errs++; $display("FAIL both_ack_c%0d: got %b want %b", c, {bus.m0_ack, bus.m1_ack}, {(c == 2 || c == 8), (c == 5)}); end
        end
        checks++; if ({bus.m0_rdata, bus.m1_rdata} !== {ref_mem[8'h30], ref_mem[8'h40]})
            begin errs++; $display("FAIL both_rdata: got %h want %h", {bus.m0_rdata, bus.m1_rdata}, {ref_mem[8'h30], ref_mem[8'h40]}); end
        idle_masters(); model_last = M0;
        @(negedge clock);
    endtask

    task automatic test_late_request();
        bus.m0_req = 1'b1; bus.m0_addr = 16'h0050;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            if (c == 1) begin bus.m1_req = 1'b1; bus.m1_addr = 16'h0060; end
            if (c >= 2) begin
                checks++;
                if ({bus.m0_ack, bus.m1_ack} !== {(c == 2), (c == 5)})
                    begin errs++; $display("FAIL late_ack_c%0d: got %b want %b", c, {bus.m0_ack, bus.m1_ack}, {(c == 2), (c == 5)}); end
            end
        end
        checks++; if (bus.m1_rdata !== ref_mem[8'h60])
            begin errs++; $display("FAIL late_rdata: got %h want %h", bus.m1_rdata, ref_mem[8'h60]); end
        idle_masters(); model_last = M1;
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        @(negedge clock);
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 16'h0070; bus.m0_wdata = 16'hCAFE;
        @(negedge clock);
        checks++; if (bus.mem_write !== 1'b1)
            begin errs++; $display("FAIL abort_pre_write: got %b want 1", bus.mem_write); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({bus.mem_write, bus.mem_read, bus.busy, bus.m0_ack} !== 4'b0000)
            begin errs++; $display("FAIL abort_immediate: got %b want 0000", {bus.mem_write, bus.mem_read, bus.busy, bus.m0_ack}); end
        idle_masters();
        @(negedge clock);
        reset = 1'b1; model_last = M1;
        #1;
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata} !== 64'h0)
            begin errs++; $display("FAIL abort_regs: got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.m0_rdata, bus.m1_rdata}); end
        checks++; if (bus.grant_id !== M0)
            begin errs++; $display("FAIL abort_gid: got %b want 0", bus.grant_id); end
        checks++; if (dmem[8'h70] !== ref_mem[8'h70])
            begin errs++; $display("FAIL abort_no_write: got %h want %h", dmem[8'h70], ref_mem[8'h70]); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checks++; if ({bus.m0_ack, bus.m1_ack, bus.busy} !== 3'b000)
                begin errs++; $display("FAIL abort_quiet_c%0d: got %b want 000", c, {bus.m0_ack, bus.m1_ack, bus.busy}); end
        end
    endtask

    task automatic test_drop();
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0020;
        @(negedge clock);   // ACCESS
        bus.m1_req = 1'b0;
        @(negedge clock);   // RESP
        checks++; if ({bus.m1_ack, bus.m1_rdata} !== {1'b1, ref_mem[8'h20]})
            begin errs++; $display("FAIL drop_ack: got %b/%h want 1/%h", bus.m1_ack, bus.m1_rdata, ref_mem[8'h20]); end
        model_last = M1;
        for (int c = 3; c <= 4; c++) begin
            @(negedge clock);
            checks++; if ({bus.busy, bus.m0_ack, bus.m1_ack} !== 3'b000)
                begin errs++; $display("FAIL drop_idle_c%0d: got %b want 000", c, {bus.busy, bus.m0_ack, bus.m1_ack}); end
        end
    endtask

    // Random rounds: each round one or both masters raise a request and hold
    // it until acked. The model serves a lone requester at once; on a tie the
    // master that did not go last is served first and the other 3 cycles later.
    task automatic test_random();
        logic          r0, r1, w0, w1, first;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, exp0, exp1;
        int            t0, t1, pick;
        do_reset();
        exp0 = '0; exp1 = '0;
        for (int r = 0; r < 40; r++) begin
            pick = int'($urandom_range(1, 3));
            r0 = pick[0]; r1 = pick[1];
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            a0 = {8'($urandom), 8'($urandom_range(0, 7))};
            a1 = {8'($urandom), 8'($urandom_range(0, 7))};
            d0 = 16'($urandom); d1 = 16'($urandom);
            first = (r0 && r1) ? ~model_last : r1;
            model_last = (r0 && r1) ? ~first : first;
            t0 = !r0 ? 0 : ((first == M0) ? 2 : 5);
            t1 = !r1 ? 0 : ((first == M1) ? 2 : 5);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
            bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clock);
                checks++;
                if ({bus.m0_ack, bus.m1_ack} !== {(c == t0), (c == t1)})
                    begin errs++; $display("FAIL rnd%0d_ack_c%0d: got %b want %b", r, c, {bus.m0_ack, bus.m1_ack}, {(c == t0), (c == t1)}); end
                if (c == t0 - 1 || c == t1 - 1) begin
                    checks++;
                    if (c == t0 - 1) begin
                        if ({bus.mem_write, bus.mem_read, bus.mem_addr} !== {w0, ~w0, a0})
                            begin errs++; $display("FAIL rnd%0d_m0_access: got %b%b/%h want %b%b/%h", r, bus.mem_write, bus.mem_read, bus.mem_addr, w0, ~w0, a0); end
                    end else begin
                        if ({bus.mem_write, bus.mem_read, bus.mem_addr} !== {w1, ~w1, a1})
                            begin errs++; $display("FAIL rnd%0d_m1_access: got %b%b/%h want %b%b/%h", r, bus.mem_write, bus.mem_read, bus.mem_addr, w1, ~w1, a1); end
                    end
                end
                if (c == t0) begin
                    if (w0) ref_mem[a0[7:0]] = d0; else exp0 = ref_mem[a0[7:0]];
                    checks++; if (bus.m0_rdata !== exp0)
                        begin errs++; $display("FAIL rnd%0d_m0_rdata: got %h want %h", r, bus.m0_rdata, exp0); end
                    bus.m0_req = 1'b0;
                end
                if (c == t1) begin
                    if (w1) ref_mem[a1[7:0]] = d1; else exp1 = ref_mem[a1[7:0]];
                    checks++; if (bus.m1_rdata !== exp1)
                        begin errs++; $display("FAIL rnd%0d_m1_rdata: got %h want %h", r, bus.m1_rdata, exp1); end
                    bus.m1_req = 1'b0;
                end
            end
        end
        idle_masters();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        model_last = M1;
        test_reset();
        test_read();
        test_write_readback();
        test_both_from_reset();
        test_late_request();
        test_reset_abort();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
